// File: rtl/memory_access_block.sv
// Memory-access pipeline stage: passes ALU results through, performs stores in
// one cycle, and performs loads in two cycles with a single upstream stall.
module memory_access_block #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ans_ex,
    input  logic [15:0] b_ex,
    input  logic        mem_en_ex,
    input  logic        mem_rw_ex,
    input  logic        valid_ex,
    output logic [15:0] ans_dm,
    output logic        valid_dm,
    output logic        stall_dm
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         ans_q, ans_d;
    logic                valid_q, valid_d;
    logic [15:0]         rd_q, rd_d;
    logic                we_s;
    logic                stall_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [15:0]         mem_q [0:DEPTH-1];

    // Upper address bits are dropped on purpose: addresses alias modulo depth.
    assign addr_s = ans_ex[ADDR_W-1:0];

    // Next-state, result and memory-write decode for the two-state stage FSM.
    always_comb begin
        state_d = state_q;
        ans_d   = ans_q;
        valid_d = 1'b0;
        rd_d    = rd_q;
        we_s    = 1'b0;
        stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_ex) begin
                    if (mem_en_ex && !mem_rw_ex) begin
                        // Load: capture the word now, present it next cycle.
                        stall_s = 1'b1;
                        rd_d    = mem_q[addr_s];
                        state_d = LOAD_WAIT;
                        valid_d = 1'b0;
                    end else begin
                        // Pass-through or store: result is the ALU value.
                        ans_d   = ans_ex;
                        valid_d = 1'b1;
                        we_s    = mem_en_ex & ~reset;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            LOAD_WAIT: begin
                // Inputs are ignored here; upstream re-presents after the stall.
                ans_d   = rd_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Stage registers; reset aborts any load in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ans_q   <= 16'h0000;
            valid_q <= 1'b0;
            rd_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ans_q   <= ans_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    // Data memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[addr_s] <= b_ex;
        end
    end

    assign ans_dm   = ans_q;
    assign valid_dm = valid_q;
    assign stall_dm = stall_s & ~reset;

endmodule

// File: doc/memory_access_block.md
MEMORY_ACCESS_BLOCK -- requirements
Module: memory_access_block

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: data-memory address width; depth is 2**ADDR_W words of 16 bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port ans_ex, input, 16: ALU result from execute; it is the memory address for loads and stores, and the pass-through value otherwise.
REQ-005 SHALL have port b_ex, input, 16: store data.
REQ-006 SHALL have port mem_en_ex, input, 1: instruction accesses memory.
REQ-007 SHALL have port mem_rw_ex, input, 1: 1 = store, 0 = load; meaningful only when mem_en_ex=1.
REQ-008 SHALL have port valid_ex, input, 1: execute-stage outputs hold a real instruction.
REQ-009 SHALL have port ans_dm, output, 16: registered stage result to write-back.
REQ-010 SHALL have port valid_dm, output, 1: ans_dm holds a retired instruction's result.
REQ-011 SHALL have port stall_dm, output, 1: combinational; upstream holds its inputs while stall_dm=1.

Function
REQ-012 SHALL contain an internal 2**ADDR_W x 16 data memory addressed by ans_ex[ADDR_W-1:0]; upper address bits SHALL be ignored (aliasing, no fault).
REQ-013 SHALL implement a two-state FSM: IDLE and LOAD_WAIT.
REQ-014 In IDLE, with valid_ex=1 and mem_en_ex=0, SHALL register ans_dm<=ans_ex and valid_dm<=1 on the next edge (1-cycle latency).
REQ-015 In IDLE, with valid_ex=1, mem_en_ex=1 and mem_rw_ex=1, SHALL write b_ex to mem[addr] on the next edge, register ans_dm<=ans_ex and valid_dm<=1; no stall.
REQ-016 In IDLE, with valid_ex=1, mem_en_ex=1 and mem_rw_ex=0, SHALL assert stall_dm=1 in that cycle, latch mem[addr] into an internal read register on the edge, go to LOAD_WAIT and drive valid_dm<=0.
REQ-017 In LOAD_WAIT, stall_dm SHALL be 0; on the next edge SHALL register ans_dm<=read register, valid_dm<=1 and return to IDLE; ex inputs in that cycle SHALL be ignored (upstream presents them again after the stall is released).
REQ-018 Total load latency SHALL be 2 cycles from first presentation to valid_dm=1; stall_dm SHALL be high for exactly 1 cycle per load.
REQ-019 With valid_ex=0 in IDLE, SHALL keep ans_dm unchanged, drive valid_dm<=0, and not write memory.
REQ-020 A load from an address stored on the immediately preceding edge SHALL return the newly stored value (read-after-write).
REQ-021 Memory SHALL be written only in IDLE with valid_ex=mem_en_ex=mem_rw_ex=1; no write in LOAD_WAIT.
REQ-022 stall_dm SHALL depend only on FSM state and current ex inputs: IDLE & valid_ex & mem_en_ex & ~mem_rw_ex.

Reset
REQ-023 While reset=1, SHALL force ans_dm=16'h0000, valid_dm=0, FSM=IDLE and read register=0 immediately, without waiting for clk.
REQ-024 While reset=1, stall_dm SHALL be 0 and memory SHALL NOT be written.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Reset asserted in LOAD_WAIT SHALL abort the load; after release, the FSM SHALL be in IDLE with no result emitted.
REQ-027 On the first edge after reset deassertion, SHALL behave per REQ-014..REQ-019.

Verification
REQ-028 ALU pass-through: valid_ex=1, mem_en_ex=0, ans_ex=16'h1234 -> next edge ans_dm=16'h1234, valid_dm=1, stall_dm=0 throughout.
REQ-029 Store then load: store b_ex=16'hBEEF at ans_ex=16'h0010, then load at 16'h0010 on the next cycle -> stall_dm=1 for one cycle, then ans_dm=16'hBEEF, valid_dm=1 two edges after the load is presented.
REQ-030 Aliasing: store 16'hCAFE at ans_ex=16'h0105, load at 16'h0005 -> ans_dm=16'hCAFE.
REQ-031 Reset mid-load: assert reset between edges while in LOAD_WAIT -> ans_dm=0, valid_dm=0 and stall_dm=0 immediately; no valid result after release.
REQ-032 Bubble: valid_ex=0 with mem_en_ex=1, mem_rw_ex=1 -> no memory write (a later load returns the old value), valid_dm=0, ans_dm held.
REQ-033 Back-to-back loads to 16'h0001 and 16'h0002 holding 16'h0011 and 16'h0022 -> results 16'h0011 then 16'h0022, with each load stalling once, in order.
